i2c_burst_avalon_bridge: RTL and testbench

- Avalon-MM slave containing its own I2C bit engine; runs one complete I2C transaction of 1..MAX_BYTES bytes per software "go".
- Replaces the bridge-plus-separate-master pairing: fixed per-byte byte ordering, sticky done/error status, optional interrupt, no waitrequest stalls.
- Sits between the HPS/Nios Avalon fabric and one I2C bus of sensors/motor boards.

---
 rtl/i2c_burst_avalon_bridge.sv | 238 +++++++++++++++++++++++
 tb/tb_i2c_burst_avalon_bridge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_burst_avalon_bridge.sv
// rtl/i2c_burst_avalon_bridge.sv - Avalon-MM slave with built-in I2C master running 1..MAX_BYTES byte bursts per go.
module i2c_burst_avalon_bridge #(
    parameter int CLK_HZ    = 50000000,
    parameter int SCL_HZ    = 400000,
    parameter int MAX_BYTES = 4,
    parameter int QDIV      = CLK_HZ / (4 * SCL_HZ)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        irq,
    inout  wire         scl,
    inout  wire         sda
);
    localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);
    localparam logic [3:0] MAXB = 4'(MAX_BYTES);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WBYTE, S_WACK, S_RBYTE, S_MACK, S_STOP
    } state_t;

    state_t        state;
    logic [QW-1:0] qcnt;
    logic [1:0]    phase;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          sampled;
    logic          scl_oe, sda_oe;
    logic [6:0]    addr_reg;
    logic [31:0]   wdata_reg, rdata_reg;
    logic          rw_reg, irq_en, busy, ack_error, done;
    logic [3:0]    nbytes, count, count_next, nb_clamp;
    logic          tick, go, sda_in, last_byte;
    logic [7:0]    first_byte, next_byte;
    logic          unused_inputs;

    assign scl = scl_oe ? 1'b0 : 1'bz;
    assign sda = sda_oe ? 1'b0 : 1'bz;
    assign sda_in = sda;
    assign unused_inputs = &{1'b0, read, scl};

    assign waitrequest = 1'b0;
    assign irq         = done & irq_en;
    assign tick        = (state != S_IDLE) && (qcnt == QMAX);
    assign go          = write && !busy && (address == 3'd3) && writedata[0];
    assign count_next  = count + 4'd1;
    assign last_byte   = (count_next == nbytes);
    assign first_byte  = 8'(wdata_reg >> {count[1:0], 3'b000});
    assign next_byte   = 8'(wdata_reg >> {count_next[1:0], 3'b000});

    always_comb begin
        nb_clamp = writedata[7:4];
        if (nb_clamp == 4'd0)
            nb_clamp = 4'd1;
        else if (nb_clamp > MAXB)
            nb_clamp = MAXB;
    end

    always_comb begin
        readdata = 32'hDEAD_BEEF;
        case (address)
            3'd0: readdata = {25'd0, addr_reg};
            3'd1: readdata = wdata_reg;
            3'd2: readdata = rdata_reg;
            3'd3: readdata = {24'd0, nbytes, 1'b0, irq_en, rw_reg, 1'b0};
            3'd4: readdata = {24'd0, count, 1'b0, done, ack_error, busy};
            default: readdata = 32'hDEAD_BEEF;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            qcnt      <= '0;
            phase     <= 2'd0;
            bitcnt    <= 3'd0;
            shreg     <= 8'd0;
            sampled   <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            addr_reg  <= 7'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            rw_reg    <= 1'b0;
            irq_en    <= 1'b0;
            nbytes    <= 4'd0;
            busy      <= 1'b0;
            ack_error <= 1'b0;
            done      <= 1'b0;
            count     <= 4'd0;
        end else begin
            if (write && !busy) begin
                case (address)
                    3'd0: addr_reg <= writedata[6:0];
                    3'd1: wdata_reg <= writedata;
                    3'd3: begin
                        rw_reg <= writedata[1];
                        irq_en <= writedata[2];
                        nbytes <= nb_clamp;
                    end
                    default: ;
                endcase
            end
            if (write && (address == 3'd4) && writedata[2])
                done <= 1'b0;

            if (state == S_IDLE || qcnt == QMAX)
                qcnt <= '0;
            else
                qcnt <= qcnt + QW'(1);

            if (go) begin
                state     <= S_START;
                busy      <= 1'b1;
                done      <= 1'b0;
                ack_error <= 1'b0;
                count     <= 4'd0;
                rdata_reg <= 32'd0;
                sda_oe    <= 1'b1;
                scl_oe    <= 1'b0;
                phase     <= 2'd0;
            end else if (tick) begin
                phase <= phase + 2'd1;
                case (state)
                    S_START: begin
                        if (phase == 2'd1) begin
                            scl_oe <= 1'b1;
                            phase  <= 2'd0;
                            state  <= S_ADDR;
                            shreg  <= {addr_reg, rw_reg};
                            sda_oe <= ~addr_reg[6];
                            bitcnt <= 3'd7;
                        end
                    end
                    S_STOP: begin
                        case (phase)
                            2'd0: scl_oe <= 1'b0;
                            2'd1: sda_oe <= 1'b0;
                            2'd3: begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    default: begin
                        case (phase)
                            2'd1: scl_oe <= 1'b0;
                            2'd2: begin
                                sampled <= sda_in;
                                if (state == S_RBYTE)
                                    shreg <= {shreg[6:0], sda_in};
                            end
                            2'd3: begin
                                // End of a bit cell: SCL falls and SDA takes the next bit together.
                                scl_oe <= 1'b1;
                                case (state)
                                    S_ADDR, S_WBYTE: begin
                                        if (bitcnt == 3'd0) begin
                                            state  <= (state == S_ADDR) ? S_AACK : S_WACK;
                                            sda_oe <= 1'b0;
                                        end else begin
                                            bitcnt <= bitcnt - 3'd1;
                                            shreg  <= {shreg[6:0], 1'b0};
                                            sda_oe <= ~shreg[6];
                                        end
                                    end
                                    S_AACK: begin
                                        bitcnt <= 3'd7;
                                        if (sampled) begin
                                            ack_error <= 1'b1;
                                            state     <= S_STOP;
                                            sda_oe    <= 1'b1;
                                        end else if (rw_reg) begin
                                            state  <= S_RBYTE;
                                            sda_oe <= 1'b0;
                                        end else begin
                                            state  <= S_WBYTE;
                                            shreg  <= first_byte;
                                            sda_oe <= ~first_byte[7];
                                        end
                                    end
                                    S_WACK: begin
                                        bitcnt <= 3'd7;
                                        if (sampled) begin
                                            ack_error <= 1'b1;
                                            state     <= S_STOP;
                                            sda_oe    <= 1'b1;
                                        end else begin
                                            count <= count_next;
                                            if (last_byte) begin
                                                state  <= S_STOP;
                                                sda_oe <= 1'b1;
                                            end else begin
                                                state  <= S_WBYTE;
                                                shreg  <= next_byte;
                                                sda_oe <= ~next_byte[7];
                                            end
                                        end
                                    end
                                    S_RBYTE: begin
                                        if (bitcnt == 3'd0) begin
                                            state  <= S_MACK;
                                            sda_oe <= ~last_byte;
                                        end else begin
                                            bitcnt <= bitcnt - 3'd1;
                                        end
                                    end
                                    S_MACK: begin
                                        rdata_reg <= rdata_reg | (32'(shreg) << {count[1:0], 3'b000});
                                        count     <= count_next;
                                        bitcnt    <= 3'd7;
                                        if (last_byte) begin
                                            state  <= S_STOP;
                                            sda_oe <= 1'b1;
                                        end else begin
                                            state  <= S_RBYTE;
                                            sda_oe <= 1'b0;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_burst_avalon_bridge.sv
// tb/tb_i2c_burst_avalon_bridge.sv - scoreboard bench with an I2C slave model for i2c_burst_avalon_bridge.
module tb_i2c_burst_avalon_bridge;
    localparam int QDIV = 4;
    localparam logic [3:0] K_START = 4'd1, K_BYTE = 4'd2, K_STOP = 4'd3;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        write, read;
    logic [31:0] writedata;
    wire  [31:0] readdata;
    wire         waitrequest, irq;
    wire         scl, sda;

    pullup (scl);
    pullup (sda);

    logic sl_oe = 1'b0;
    assign sda = sl_oe ? 1'b0 : 1'bz;

    i2c_burst_avalon_bridge #(
        .CLK_HZ(1600000), .SCL_HZ(100000), .MAX_BYTES(4)
    ) dut (
        .clock(clock), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .waitrequest(waitrequest), .irq(irq), .scl(scl), .sda(sda)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    logic [15:0] bus_q[$];
    logic [31:0] reg_q[$];
    logic [2:0]  rega_q[$];
    logic [7:0]  tx_q[$];
    logic        ack_addr = 1'b1;
    int          bus_seen = 0;
    int          cyc = 0;
    int          last_rise = 0;
    int          last_period = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] tok(input logic [3:0] k, input logic ack, input logic [7:0] b);
        return {k, ack, 3'b000, b};
    endfunction

    task automatic exp_bus(input logic [3:0] k, input logic ack, input logic [7:0] b);
        bus_q.push_back(tok(k, ack, b));
    endtask

    task automatic bus_event(input logic [15:0] t);
        bus_seen++;
        if (bus_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL bus_unexpected actual=%h expected=none", t);
        end else begin
            chk("bus_token", {16'd0, t}, {16'd0, bus_q.pop_front()});
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Register monitor: every read strobe pops one expected value.
    initial forever begin
        @(negedge clock);
        if (read === 1'b1 && reset === 1'b0) begin
            if (reg_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL reg_unexpected actual=%h expected=none", readdata);
            end else begin
                chk($sformatf("reg_%0d", rega_q.pop_front()), readdata, reg_q.pop_front());
            end
        end
    end

    // I2C slave model and bus monitor, sampled on the falling system clock edge.
    initial begin
        logic ps, pd, s, d, active, is_addr, slave_tx;
        logic [7:0] rx, tx;
        int bitn;
        ps = 1'b1; pd = 1'b1; active = 1'b0; is_addr = 1'b0; slave_tx = 1'b0;
        rx = 8'd0; tx = 8'd0; bitn = 0;
        forever begin
            @(negedge clock);
            s = (scl === 1'b0) ? 1'b0 : 1'b1;
            d = (sda === 1'b0) ? 1'b0 : 1'b1;
            if (reset === 1'b1) begin
                ps = 1'b1; pd = 1'b1; active = 1'b0; sl_oe = 1'b0; slave_tx = 1'b0;
            end else begin
                if (ps && s && pd && !d) begin
                    active = 1'b1; bitn = 0; is_addr = 1'b1; slave_tx = 1'b0; sl_oe = 1'b0;
                    bus_event(tok(K_START, 1'b0, 8'h00));
                end else if (ps && s && !pd && d) begin
                    active = 1'b0; sl_oe = 1'b0;
                    bus_event(tok(K_STOP, 1'b0, 8'h00));
                end else if (active && ps && !s) begin
                    if (bitn == 8) begin
                        sl_oe = slave_tx ? 1'b0 : (is_addr ? ack_addr : 1'b1);
                    end else if (bitn == 9) begin
                        sl_oe = 1'b0;
                        bitn = 0;
                        if (slave_tx) begin
                            tx = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hFF;
                            sl_oe = ~tx[7];
                        end
                    end else if (slave_tx && bitn > 0) begin
                        sl_oe = ~tx[7 - bitn];
                    end
                end else if (active && !ps && s) begin
                    if (bitn < 8) begin
                        if (bitn >= 1) last_period = cyc - last_rise;
                        last_rise = cyc;
                        rx = {rx[6:0], d};
                        bitn++;
                    end else if (bitn == 8) begin
                        bus_event(tok(K_BYTE, d, rx));
                        if (is_addr) begin
                            is_addr = 1'b0;
                            slave_tx = rx[0] & ~d;
                        end else if (slave_tx && d) begin
                            slave_tx = 1'b0;
                        end
                        bitn = 9;
                    end
                end
                ps = s;
                pd = d;
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] dat);
        @(posedge clock); #1;
        address = a; writedata = dat; write = 1'b1;
        @(posedge clock); #1;
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e);
        reg_q.push_back(e);
        rega_q.push_back(a);
        @(posedge clock); #1;
        address = a; read = 1'b1;
        @(posedge clock); #1;
        read = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        address = 3'd4;
        @(negedge clock);
        while (readdata[2] !== 1'b1 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy expected=done", name);
        end
        repeat (4) @(posedge clock);
        #1;
    endtask

    initial begin
        int base, n;
        reset = 1'b1; write = 1'b0; read = 1'b0; address = 3'd0; writedata = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_scl", {31'd0, scl}, 32'd1);
        chk("reset_sda", {31'd0, sda}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        rd(3'd4, 32'h0);
        rd(3'd3, 32'h0);
        rd(3'd7, 32'hDEAD_BEEF);
        rd(3'd2, 32'h0);
        chk("waitrequest", {31'd0, waitrequest}, 32'd0);

        // two-byte write
        wr(3'd0, 32'h68);
        wr(3'd1, 32'h0000_CDAB);
        exp_bus(K_START, 0, 8'h00); exp_bus(K_BYTE, 0, 8'hD0);
        exp_bus(K_BYTE, 0, 8'hAB);  exp_bus(K_BYTE, 0, 8'hCD);
        exp_bus(K_STOP, 0, 8'h00);
        wr(3'd3, 32'h21);
        wait_done("write2");
        rd(3'd4, 32'h24);
        rd(3'd3, 32'h20);
        chk("scl_period", last_period, 4 * QDIV);

        // three-byte read
        tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
        exp_bus(K_START, 0, 8'h00); exp_bus(K_BYTE, 0, 8'hD1);
        exp_bus(K_BYTE, 0, 8'h11);  exp_bus(K_BYTE, 0, 8'h22);
        exp_bus(K_BYTE, 1, 8'h33);  exp_bus(K_STOP, 0, 8'h00);
        wr(3'd3, 32'h33);
        wait_done("read3");
        rd(3'd2, 32'h0033_2211);
        rd(3'd4, 32'h34);

        // address NACK with interrupt enabled
        ack_addr = 1'b0;
        exp_bus(K_START, 0, 8'h00); exp_bus(K_BYTE, 1, 8'hD0); exp_bus(K_STOP, 0, 8'h00);
        wr(3'd3, 32'h25);
        wait_done("nack");
        rd(3'd4, 32'h06);
        rd(3'd2, 32'h0);
        @(negedge clock);
        chk("irq_set", {31'd0, irq}, 32'd1);
        wr(3'd4, 32'h4);
        @(negedge clock);
        chk("irq_clear", {31'd0, irq}, 32'd0);
        rd(3'd4, 32'h02);
        ack_addr = 1'b1;

        // nbytes=0 runs one byte; writes while busy are dropped
        wr(3'd1, 32'h5A);
        exp_bus(K_START, 0, 8'h00); exp_bus(K_BYTE, 0, 8'hD0);
        exp_bus(K_BYTE, 0, 8'h5A);  exp_bus(K_STOP, 0, 8'h00);
        wr(3'd3, 32'h01);
        repeat (20) @(posedge clock);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd3, 32'h47);
        wr(3'd0, 32'h11);
        wait_done("busywr");
        rd(3'd1, 32'h5A);
        rd(3'd3, 32'h10);
        rd(3'd0, 32'h68);
        rd(3'd4, 32'h14);
        wr(3'd3, 32'h96);
        rd(3'd3, 32'h46);
        wr(3'd3, 32'h00);
        rd(3'd3, 32'h10);

        // reset during the second data byte
        wr(3'd1, 32'h4433_2211);
        base = bus_seen;
        exp_bus(K_START, 0, 8'h00); exp_bus(K_BYTE, 0, 8'hD0); exp_bus(K_BYTE, 0, 8'h11);
        wr(3'd3, 32'h41);
        n = 0;
        while (bus_seen < base + 3 && n < 5000) begin
            @(posedge clock);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL midreset_wait actual=%0d expected=%0d", bus_seen - base, 3);
        end
        repeat (2 * 4 * QDIV) @(posedge clock);
        n = 0;
        @(negedge clock);
        while (scl !== 1'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("midreset_scl_low", {31'd0, scl}, 32'd0);
        reset = 1'b1;
        #1;
        chk("midreset_scl_z", {31'd0, scl}, 32'd1);
        chk("midreset_sda_z", {31'd0, sda}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        rd(3'd4, 32'h0);
        rd(3'd3, 32'h0);
        rd(3'd1, 32'h0);
        wr(3'd0, 32'h68);
        wr(3'd1, 32'h77);
        exp_bus(K_START, 0, 8'h00); exp_bus(K_BYTE, 0, 8'hD0);
        exp_bus(K_BYTE, 0, 8'h77);  exp_bus(K_STOP, 0, 8'h00);
        wr(3'd3, 32'h11);
        wait_done("after_reset");
        rd(3'd4, 32'h14);

        repeat (5) @(posedge clock);
        chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
        chk("reg_queue_empty", 32'(reg_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
